// File: rtl/pixel_sensor_ctrl.sv
// Frame sequencer for the pixel array: erase, expose, 256-step ramp conversion,
// then row-by-row readout with a valid/ready handshake to the capture logic.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   IDLE    | waiting for START, all outputs low
//   ERASE   | ERASE high, timer counts ERASE_CYCLES down
//   EXPOSE  | EXPOSE high, timer counts EXPOSE_CYCLES down
//   CONVERT | RAMP high, COUNTER steps 0..255
//   READ    | one-hot row select, settle cycle then DATA_VALID
//   DONE    | one-cycle FRAME_DONE pulse
module pixel_sensor_ctrl #(
  parameter int PIXEL_ARRAY_HEIGHT = 2,
  parameter int ERASE_CYCLES       = 5,
  parameter int EXPOSE_CYCLES      = 255
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          START,
  input  logic                          DATA_READY,
  output logic                          ERASE,
  output logic                          EXPOSE,
  output logic                          RAMP,
  output logic [7:0]                    COUNTER,
  output logic [PIXEL_ARRAY_HEIGHT-1:0] READ,
  output logic                          DATA_VALID,
  output logic [((PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1)-1:0] ROW_ADDR,
  output logic                          BUSY,
  output logic                          FRAME_DONE
);

  localparam int ROW_W = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ERASE   = 3'd1;
  localparam logic [2:0] S_EXPOSE  = 3'd2;
  localparam logic [2:0] S_CONVERT = 3'd3;
  localparam logic [2:0] S_READ    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [15:0]      ERASE_LOAD  = 16'(ERASE_CYCLES - 1);
  localparam logic [15:0]      EXPOSE_LOAD = 16'(EXPOSE_CYCLES - 1);
  localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);

  logic [2:0]                    state, state_nx;
  logic [15:0]                   timer, timer_nx;
  logic [ROW_W-1:0]              row, row_nx;
  logic [7:0]                    cnt, cnt_nx;
  logic                          vld, vld_nx;
  logic [PIXEL_ARRAY_HEIGHT-1:0] read_nx;

  always_comb begin
    state_nx = state;
    timer_nx = timer;
    row_nx   = row;
    cnt_nx   = cnt;
    vld_nx   = vld;
    case (state)
      S_IDLE: begin
        if (START) begin
          state_nx = S_ERASE;
          timer_nx = ERASE_LOAD;
        end
      end
      S_ERASE: begin
        if (timer == 16'd0) begin
          state_nx = S_EXPOSE;
          timer_nx = EXPOSE_LOAD;
        end else begin
          timer_nx = timer - 16'd1;
        end
      end
      S_EXPOSE: begin
        if (timer == 16'd0) begin
          state_nx = S_CONVERT;
          cnt_nx   = 8'd0;
        end else begin
          timer_nx = timer - 16'd1;
        end
      end
      S_CONVERT: begin
        // the ramp ends after the code-255 cycle, so the counter never wraps
        if (cnt == 8'hFF) begin
          state_nx = S_READ;
          cnt_nx   = 8'd0;
          row_nx   = '0;
          vld_nx   = 1'b0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      S_READ: begin
        if (!vld) begin
          vld_nx = 1'b1;
        end else if (DATA_READY) begin
          vld_nx = 1'b0;
          if (row == LAST_ROW) begin
            state_nx = S_DONE;
            row_nx   = '0;
          end else begin
            row_nx = row + ROW_W'(1);
          end
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
        timer_nx = 16'd0;
        row_nx   = '0;
        cnt_nx   = 8'd0;
        vld_nx   = 1'b0;
      end
    endcase
  end

  always_comb begin
    read_nx = '0;
    for (int i = 0; i < PIXEL_ARRAY_HEIGHT; i++) begin
      read_nx[i] = (state_nx == S_READ) && (int'(row_nx) == i);
    end
  end

  // outputs are registered from the next-state decode so they only move at an edge
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state      <= S_IDLE;
      timer      <= 16'd0;
      row        <= '0;
      cnt        <= 8'd0;
      vld        <= 1'b0;
      ERASE      <= 1'b0;
      EXPOSE     <= 1'b0;
      RAMP       <= 1'b0;
      READ       <= '0;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      state      <= state_nx;
      timer      <= timer_nx;
      row        <= row_nx;
      cnt        <= cnt_nx;
      vld        <= vld_nx;
      ERASE      <= (state_nx == S_ERASE);
      EXPOSE     <= (state_nx == S_EXPOSE);
      RAMP       <= (state_nx == S_CONVERT);
      READ       <= read_nx;
      BUSY       <= (state_nx != S_IDLE);
      FRAME_DONE <= (state_nx == S_DONE);
    end
  end

  assign COUNTER    = cnt;
  assign DATA_VALID = vld;
  assign ROW_ADDR   = row;

endmodule

// File: tb/tb_pixel_sensor_ctrl.sv
// Bench for pixel_sensor_ctrl: directed frame scenarios plus random traffic,
// every cycle checked against a frame-position reference model.
module tb_pixel_sensor_ctrl;
  localparam int H = 2;
  localparam int E = 5;
  localparam int X = 10;
  localparam int T = E + X + 256;
  localparam int FRAME_BUSY = E + X + 256 + 2 * H + 1;

  logic         CLK = 1'b0;
  logic         RESET, START, DATA_READY;
  logic         ERASE, EXPOSE, RAMP, DATA_VALID, BUSY, FRAME_DONE;
  logic [7:0]   COUNTER;
  logic [H-1:0] READ;
  logic [0:0]   ROW_ADDR;

  pixel_sensor_ctrl #(
    .PIXEL_ARRAY_HEIGHT(H),
    .ERASE_CYCLES(E),
    .EXPOSE_CYCLES(X)
  ) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .DATA_READY(DATA_READY),
    .ERASE(ERASE), .EXPOSE(EXPOSE), .RAMP(RAMP), .COUNTER(COUNTER),
    .READ(READ), .DATA_VALID(DATA_VALID), .ROW_ADDR(ROW_ADDR),
    .BUSY(BUSY), .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;
  int busy_cnt = 0;
  int done_cnt = 0;
  int cyc      = 0;

  // reference model: position within the frame, el = cycles since ERASE rose
  bit m_in, m_done, m_vld;
  int m_el, m_row;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_tick();
    if (!RESET) begin
      m_in = 0; m_done = 0; m_vld = 0; m_el = 0; m_row = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_in) begin
      if (START) begin
        m_in = 1; m_el = 0; m_row = 0; m_vld = 0;
      end
    end else if (m_el < T) begin
      m_el++;
    end else if (!m_vld) begin
      m_vld = 1;
    end else if (DATA_READY) begin
      if (m_row < H - 1) begin
        m_row++; m_vld = 0;
      end else begin
        m_in = 0; m_done = 1; m_row = 0; m_vld = 0;
      end
    end
  endtask

  task automatic check_all();
    bit rd, rmp;
    rd  = m_in && (m_el == T);
    rmp = m_in && (m_el >= E + X) && (m_el < T);
    chk("ERASE",      ERASE,      m_in && (m_el < E));
    chk("EXPOSE",     EXPOSE,     m_in && (m_el >= E) && (m_el < E + X));
    chk("RAMP",       RAMP,       rmp);
    chk("COUNTER",    COUNTER,    rmp ? m_el - E - X : 0);
    chk("READ",       READ,       rd ? (32'd1 << m_row) : 32'd0);
    chk("DATA_VALID", DATA_VALID, rd && m_vld);
    chk("ROW_ADDR",   ROW_ADDR,   rd ? m_row : 0);
    chk("BUSY",       BUSY,       m_in || m_done);
    chk("FRAME_DONE", FRAME_DONE, m_done);
  endtask

  task automatic step();
    model_tick();
    @(posedge CLK);
    #1;
    cyc++;
    check_all();
    if (BUSY) busy_cnt++;
    if (FRAME_DONE) done_cnt++;
  endtask

  // one START pulse, then run to idle; optional row-0 stall and START pokes while busy
  task automatic run_frame(input int stall, input bit poke, input int exp_busy);
    int stall_left;
    busy_cnt = 0; done_cnt = 0; stall_left = stall;
    START = 1; DATA_READY = 1;
    step();
    START = 0;
    for (int i = 0; i < 3000 && (m_in || m_done); i++) begin
      DATA_READY = 1;
      if (m_in && m_el == T && m_vld && m_row == 0 && stall_left > 0) begin
        DATA_READY = 0; stall_left--;
      end
      START = poke && m_in && (m_el == E + 3 || m_el == T);
      step();
    end
    START = 0;
    chk("frame_timeout", BUSY, 0);
    chk("busy_len", busy_cnt, exp_busy);
    chk("done_pulses", done_cnt, 1);
  endtask

  initial begin
    int first_done, second_done, idle_gap;
    RESET = 0; START = 1; DATA_READY = 0;
    m_in = 0; m_done = 0; m_vld = 0; m_el = 0; m_row = 0;

    busy_cnt = 0;
    repeat (3) step();
    chk("reset_busy", busy_cnt, 0);
    RESET = 1; START = 0;
    step();

    run_frame(0, 0, FRAME_BUSY);
    run_frame(7, 0, FRAME_BUSY + 7);
    run_frame(0, 1, FRAME_BUSY);

    // reset mid-convert
    START = 1; step(); START = 0;
    for (int i = 0; i < 1000 && !(m_in && m_el == E + X + 100); i++) step();
    chk("counter_at_100", COUNTER, 100);
    RESET = 0; step(); RESET = 1;
    chk("idle_after_reset", {BUSY, RAMP, COUNTER}, 0);
    run_frame(0, 0, FRAME_BUSY);

    // continuous START: back-to-back frames with one idle cycle between
    START = 1; DATA_READY = 1; done_cnt = 0; first_done = 0; second_done = 0; idle_gap = 0;
    for (int i = 0; i < 1000 && done_cnt < 2; i++) begin
      step();
      if (FRAME_DONE && done_cnt == 1) first_done = cyc;
      if (FRAME_DONE && done_cnt == 2) second_done = cyc;
      if (!BUSY && done_cnt == 1) idle_gap++;
    end
    START = 0;
    chk("cont_done_pulses", done_cnt, 2);
    chk("cont_idle_gap", idle_gap, 1);
    chk("cont_period", second_done - first_done, FRAME_BUSY + 1);
    repeat (3) step();

    // random traffic with rare resets
    for (int i = 0; i < 4000; i++) begin
      START      = ($urandom_range(0, 7) == 0);
      DATA_READY = $urandom_range(0, 1);
      RESET      = ($urandom_range(0, 799) != 0);
      step();
    end
    RESET = 1; START = 0; DATA_READY = 1;
    for (int i = 0; i < 3000 && (m_in || m_done); i++) step();
    chk("final_idle", BUSY, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pixel_sensor_ctrl.md
# pixel_sensor_ctrl

Frame sequencer for the pixel sensor. It sits directly upstream of the pixel array and drives the array's control inputs: ERASE, EXPOSE, RAMP, the shared 8-bit COUNTER and the one-hot READ row select. It steps one full frame per START (erase, expose, ramp conversion, row-by-row readout) and issues a valid/ready strobe so the downstream capture logic can take each row from the array's DATA_OUT bus.

## Interface
- PIXEL_ARRAY_HEIGHT, 2: number of rows; width of READ.
- ERASE_CYCLES, 5: ERASE high time in cycles; range 1..65535.
- EXPOSE_CYCLES, 255: EXPOSE high time in cycles; range 1..65535.
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-low reset.
- START  input  1  request one frame; sampled only in IDLE.
- DATA_READY  input  1  downstream accepts the current row.
- ERASE  output  1  pixel erase, to array.
- EXPOSE  output  1  pixel expose, to array.
- RAMP  output  1  ADC ramp enable, to array.
- COUNTER  output  8  ramp code, to array.
- READ  output  PIXEL_ARRAY_HEIGHT  one-hot row read enable, to array.
- DATA_VALID  output  1  array DATA_OUT holds a settled row.
- ROW_ADDR  output  max(1,$clog2(PIXEL_ARRAY_HEIGHT))  index of the row on DATA_OUT.
- BUSY  output  1  high in every state except IDLE.
- FRAME_DONE  output  1  one-cycle pulse at frame end.

## Operation
- States: IDLE, ERASE, EXPOSE, CONVERT, READ, DONE. All outputs are registered and decoded from state, timer and row registers.
- IDLE: all outputs 0. START=1 at an edge moves to ERASE. Timer loads ERASE_CYCLES-1.
- ERASE: ERASE=1. Timer decrements each cycle. At 0 go to EXPOSE and load EXPOSE_CYCLES-1.
- EXPOSE: EXPOSE=1. Same countdown. At 0 go to CONVERT with COUNTER=0.
- CONVERT: RAMP=1. COUNTER increments each cycle: 0 on the first cycle, 255 on the 256th. It never wraps inside CONVERT. After the COUNTER=255 cycle go to READ with row=0. Outside CONVERT, COUNTER=0.
- READ: READ[row]=1 with all other bits 0, and ROW_ADDR=row.
  - The first cycle of each row is a settle cycle with DATA_VALID=0.
  - From the second cycle DATA_VALID=1 and holds until DATA_VALID&&DATA_READY at an edge (transfer).
  - After a transfer: if row<PIXEL_ARRAY_HEIGHT-1, increment row and settle again; otherwise go to DONE.
- DONE: FRAME_DONE=1 for one cycle, then IDLE. BUSY=0 on the IDLE cycle.
- START outside IDLE is ignored; it is not queued.
- START held high continuously gives back-to-back frames with exactly one IDLE cycle between them.
- DATA_READY outside DATA_VALID is ignored. DATA_READY low stalls readout indefinitely; READ, ROW_ADDR and DATA_VALID stay stable.
- RESET=0 at any edge, in any state: next cycle is IDLE, timer, row and all outputs 0. No partial frame resumes.

## Timing
- Reset values: ERASE=EXPOSE=RAMP=DATA_VALID=BUSY=FRAME_DONE=0, COUNTER=0, READ=0, ROW_ADDR=0.
- START sampled at edge k: ERASE and BUSY are high from cycle k+1.
- ERASE lasts exactly ERASE_CYCLES cycles and EXPOSE exactly EXPOSE_CYCLES cycles; they are never high together.
- EXPOSE falls and RAMP rises on the same edge.
- RAMP lasts exactly 256 cycles. COUNTER equals the number of cycles since RAMP rose.
- Readout with DATA_READY=1 always takes 2 cycles per row.
- Frame length, START edge to the BUSY-low cycle: ERASE_CYCLES+EXPOSE_CYCLES+256+2·H+stall cycles+1.
- No output glitches: every output changes only at a CLK edge.

## Test plan
- Reset: hold RESET=0 for 3 cycles with START=1 -> all outputs 0 and BUSY stays 0.
- Nominal frame (H=2, ERASE_CYCLES=5, EXPOSE_CYCLES=10, DATA_READY=1), START pulse:
  - ERASE high 5 cycles, then EXPOSE high 10 cycles, then RAMP high 256 cycles with COUNTER running 0..255.
  - READ=01 for 2 cycles (DATA_VALID on the 2nd, ROW_ADDR=0), then READ=10 for 2 cycles (ROW_ADDR=1).
  - FRAME_DONE pulses once; BUSY is high for exactly 276 cycles.
- Backpressure: DATA_READY=0 for 7 cycles on row 0 -> READ=01, DATA_VALID=1 and ROW_ADDR=0 stay stable. Row 1 starts the cycle after DATA_READY rises. The frame is 7 cycles longer.
- START during busy: pulse START while in EXPOSE and again in READ -> exactly one FRAME_DONE, with no restart.
- Reset mid-convert: RESET=0 for 1 cycle when COUNTER=100 -> next cycle all outputs 0 and IDLE. A following START runs a full 276-cycle frame.
- Continuous START: hold START=1 for 2 frames -> 2 FRAME_DONE pulses, separated by one BUSY=0 cycle.
